mc_control_fsm: RTL

- Multi-cycle MIPS main controller, directly upstream of the ALU.
- Sequences each instruction through fetch, decode, execute, memory and write-back states.
- Drives the ALU's 3-bit op code and operand muxes, plus all datapath write enables.
- Consumes the ALU's ZF/OF flags for branches and optional overflow trap; handshakes with a variable-latency memory.

---
 rtl/mc_control_fsm_pkg.sv | 76 +++++++
 rtl/mc_control_fsm_alu_op_decoder.sv | 66 ++++++
 rtl/mc_control_fsm.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/mc_control_fsm_pkg.sv
// Shared definitions for the multi-cycle MIPS controller, ALU and datapath.
// Contents: state encodings, ALU op codes, opcode/funct constants,
// ALU_SRC_B / PC_SRC encodings and the overflow-sensitive op helper.
package mc_control_fsm_pkg;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC_R   = 4'd3,
    S_EXEC_I   = 4'd4,
    S_MEM_ADDR = 4'd5,
    S_MEM_RD   = 4'd6,
    S_MEM_WR   = 4'd7,
    S_WB_R     = 4'd8,
    S_WB_I     = 4'd9,
    S_WB_MEM   = 4'd10,
    S_BRANCH   = 4'd11,
    S_JUMP     = 4'd12,
    S_ILLEGAL  = 4'd13
  } state_t;

  // What the current state needs from the ALU: a fixed add (address/PC
  // arithmetic), a fixed sub (branch compare), or an IR-selected operation.
  typedef enum logic [1:0] {
    CLS_ADD   = 2'd0,
    CLS_SUB   = 2'd1,
    CLS_RTYPE = 2'd2,
    CLS_ITYPE = 2'd3
  } alu_cls_t;

  localparam logic [2:0] ALU_AND = 3'd0;
  localparam logic [2:0] ALU_OR  = 3'd1;
  localparam logic [2:0] ALU_XOR = 3'd2;
  localparam logic [2:0] ALU_NOR = 3'd3;
  localparam logic [2:0] ALU_ADD = 3'd4;
  localparam logic [2:0] ALU_SUB = 3'd5;
  localparam logic [2:0] ALU_SLT = 3'd6;
  localparam logic [2:0] ALU_SLL = 3'd7;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_SLLV = 6'h04;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;

  localparam logic [1:0] SRCB_REG    = 2'd0;
  localparam logic [1:0] SRCB_FOUR   = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  // Instructions whose signed overflow can be trapped.
  function automatic logic is_ovf_op(input logic [5:0] op, input logic [5:0] funct);
    return ((op == OP_RTYPE) && ((funct == F_ADD) || (funct == F_SUB))) ||
           (op == OP_ADDI);
  endfunction

endpackage

// File: rtl/mc_control_fsm_alu_op_decoder.sv
// Combinational ALU control decode.
// Ports:
//   cls      in  ALU usage class of the current state
//   op       in  IR[31:26]
//   funct    in  IR[5:0]
//   alu_op   out ALU operation code
//   ext_zero out zero-extend immediate (logical I-type ops)
//   legal    out OP/FUNCT pair is an implemented instruction
module mc_control_fsm_alu_op_decoder
  import mc_control_fsm_pkg::*;
(
  input  alu_cls_t   cls,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output logic [2:0] alu_op,
  output logic       ext_zero,
  output logic       legal
);

  always_comb begin
    alu_op   = ALU_ADD;
    ext_zero = 1'b0;
    case (cls)
      CLS_ADD: alu_op = ALU_ADD;
      CLS_SUB: alu_op = ALU_SUB;
      CLS_RTYPE: begin
        case (funct)
          F_ADD:   alu_op = ALU_ADD;
          F_SUB:   alu_op = ALU_SUB;
          F_AND:   alu_op = ALU_AND;
          F_OR:    alu_op = ALU_OR;
          F_XOR:   alu_op = ALU_XOR;
          F_NOR:   alu_op = ALU_NOR;
          F_SLT:   alu_op = ALU_SLT;
          F_SLLV:  alu_op = ALU_SLL;
          default: alu_op = ALU_ADD;
        endcase
      end
      CLS_ITYPE: begin
        case (op)
          OP_ANDI: begin alu_op = ALU_AND; ext_zero = 1'b1; end
          OP_ORI:  begin alu_op = ALU_OR;  ext_zero = 1'b1; end
          OP_XORI: begin alu_op = ALU_XOR; ext_zero = 1'b1; end
          default: alu_op = ALU_ADD;
        endcase
      end
      default: alu_op = ALU_ADD;
    endcase
  end

  always_comb begin
    legal = 1'b0;
    case (op)
      OP_RTYPE: begin
        case (funct)
          F_ADD, F_SUB, F_AND, F_OR, F_XOR, F_NOR, F_SLT, F_SLLV: legal = 1'b1;
          default: legal = 1'b0;
        endcase
      end
      OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_LW, OP_SW:
        legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS main controller. Steps each instruction through
// fetch/decode/execute/memory/write-back and drives ALU control, operand
// muxes, datapath write enables and a variable-latency memory handshake.
// Ports:
//   CLK, RST_N            clock, async active-low reset
//   OP, FUNCT             instruction fields from IR
//   ZF, OF                ALU flags
//   MEM_READY             memory completes current request this cycle
//   MEM_REQ/MEM_WE/IORD   memory request, write, address select
//   IR_WRITE, PC_WRITE    IR / PC load enables; PC_SRC selects PC source
//   ALU_SRC_A/B, ALU_OP   ALU operand muxes and operation
//   REG_DST, MEM_TO_REG, REG_WRITE, EXT_ZERO   register-file write controls
//   EXC                   illegal instruction / overflow trap pulse
//   INSTR_DONE            pulse in the last cycle of each instruction
//   STATE                 current state for debug
module mc_control_fsm
  import mc_control_fsm_pkg::*;
#(
  parameter int TRAP_OF = 0
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [5:0] OP,
  input  logic [5:0] FUNCT,
  input  logic       ZF,
  input  logic       OF,
  input  logic       MEM_READY,
  output logic       MEM_REQ,
  output logic       MEM_WE,
  output logic       IORD,
  output logic       IR_WRITE,
  output logic       PC_WRITE,
  output logic [1:0] PC_SRC,
  output logic       ALU_SRC_A,
  output logic [1:0] ALU_SRC_B,
  output logic [2:0] ALU_OP,
  output logic       REG_DST,
  output logic       MEM_TO_REG,
  output logic       REG_WRITE,
  output logic       EXT_ZERO,
  output logic       EXC,
  output logic       INSTR_DONE,
  output logic [3:0] STATE
);

  state_t     state_q, state_d;
  logic       of_q;
  alu_cls_t   cls;
  logic [2:0] dec_alu_op;
  logic       dec_ext_zero;
  logic       dec_legal;
  logic       trap;

  always_comb begin
    case (state_q)
      S_EXEC_R: cls = CLS_RTYPE;
      S_EXEC_I: cls = CLS_ITYPE;
      S_BRANCH: cls = CLS_SUB;
      default:  cls = CLS_ADD;
    endcase
  end

  mc_control_fsm_alu_op_decoder u_dec (
    .cls      (cls),
    .op       (OP),
    .funct    (FUNCT),
    .alu_op   (dec_alu_op),
    .ext_zero (dec_ext_zero),
    .legal    (dec_legal)
  );

  // IR is stable through write-back, so the trap qualifier can be decoded
  // straight from OP/FUNCT there; of_q carries the flag seen in EXEC.
  assign trap = (TRAP_OF != 0) && of_q && is_ovf_op(OP, FUNCT);

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      of_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_EXEC_R || state_q == S_EXEC_I) of_q <= OF;
    end
  end

  // Next-state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  if (MEM_READY) state_d = S_DECODE;
      S_DECODE: begin
        if (!dec_legal) state_d = S_ILLEGAL;
        else begin
          case (OP)
            OP_RTYPE:                         state_d = S_EXEC_R;
            OP_ADDI, OP_ANDI, OP_ORI, OP_XORI: state_d = S_EXEC_I;
            OP_LW, OP_SW:                     state_d = S_MEM_ADDR;
            OP_BEQ, OP_BNE:                   state_d = S_BRANCH;
            OP_J:                             state_d = S_JUMP;
            default:                          state_d = S_ILLEGAL;
          endcase
        end
      end
      S_EXEC_R:   state_d = S_WB_R;
      S_EXEC_I:   state_d = S_WB_I;
      S_MEM_ADDR: state_d = (OP == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   if (MEM_READY) state_d = S_WB_MEM;
      S_MEM_WR:   if (MEM_READY) state_d = S_FETCH;
      S_WB_R, S_WB_I, S_WB_MEM, S_BRANCH, S_JUMP, S_ILLEGAL:
                  state_d = S_FETCH;
      default:    state_d = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    MEM_REQ    = 1'b0;
    MEM_WE     = 1'b0;
    IORD       = 1'b0;
    IR_WRITE   = 1'b0;
    PC_WRITE   = 1'b0;
    PC_SRC     = PCSRC_ALU;
    ALU_SRC_A  = 1'b0;
    ALU_SRC_B  = SRCB_REG;
    ALU_OP     = 3'd0;
    REG_DST    = 1'b0;
    MEM_TO_REG = 1'b0;
    REG_WRITE  = 1'b0;
    EXT_ZERO   = 1'b0;
    EXC        = 1'b0;
    INSTR_DONE = 1'b0;
    case (state_q)
      S_FETCH: begin
        MEM_REQ   = 1'b1;
        ALU_SRC_B = SRCB_FOUR;
        ALU_OP    = dec_alu_op;
        // IR/PC may only load once the fetch data is actually there,
        // otherwise PC would advance on every wait cycle.
        IR_WRITE  = MEM_READY;
        PC_WRITE  = MEM_READY;
      end
      S_DECODE: begin
        ALU_SRC_B = SRCB_IMM_SH;
        ALU_OP    = dec_alu_op;
      end
      S_EXEC_R: begin
        ALU_SRC_A = 1'b1;
        ALU_SRC_B = SRCB_REG;
        ALU_OP    = dec_alu_op;
      end
      S_EXEC_I: begin
        ALU_SRC_A = 1'b1;
        ALU_SRC_B = SRCB_IMM;
        ALU_OP    = dec_alu_op;
        EXT_ZERO  = dec_ext_zero;
      end
      S_MEM_ADDR: begin
        ALU_SRC_A = 1'b1;
        ALU_SRC_B = SRCB_IMM;
        ALU_OP    = dec_alu_op;
      end
      S_MEM_RD: begin
        MEM_REQ = 1'b1;
        IORD    = 1'b1;
      end
      S_MEM_WR: begin
        MEM_REQ    = 1'b1;
        MEM_WE     = 1'b1;
        IORD       = 1'b1;
        INSTR_DONE = MEM_READY;
      end
      S_WB_R, S_WB_I: begin
        REG_DST    = (state_q == S_WB_R);
        REG_WRITE  = !trap;
        EXC        = trap;
        INSTR_DONE = 1'b1;
      end
      S_WB_MEM: begin
        MEM_TO_REG = 1'b1;
        REG_WRITE  = 1'b1;
        INSTR_DONE = 1'b1;
      end
      S_BRANCH: begin
        ALU_SRC_A  = 1'b1;
        ALU_SRC_B  = SRCB_REG;
        ALU_OP     = dec_alu_op;
        PC_SRC     = PCSRC_ALUOUT;
        PC_WRITE   = (OP == OP_BEQ) ? ZF : !ZF;
        INSTR_DONE = 1'b1;
      end
      S_JUMP: begin
        PC_WRITE   = 1'b1;
        PC_SRC     = PCSRC_JUMP;
        INSTR_DONE = 1'b1;
      end
      S_ILLEGAL: begin
        EXC        = 1'b1;
        INSTR_DONE = 1'b1;
      end
      default: ;
    endcase
  end

  assign STATE = state_q;

endmodule
